wb_stage: RTL
=============

Name: wb_stage

Overview:
- Final (MEM/WB) stage of the pipelined RV32I core.
- Registers the MEM-stage result and selects ALU, load, or PC+4 data.
- Sign- or zero-extends sub-word loads.
- Drives the register file write port (RegWrite, write_addr, write_data).
- Exports the same write as a bypass to the hazard/forwarding unit. The register file writes on the clock edge, so a same-cycle ID read returns the old value without this bypass.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-low; 0 at a rising clk edge resets the block.
- stall  input  1  hold the stage register.
- flush  input  1  load a bubble into the stage register.
- mem_valid  input  1  MEM stage holds a real instruction.
- mem_reg_write  input  1  instruction writes rd.
- mem_rd  input  REG_ADDR_W  destination register.
- mem_result_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- mem_funct3  input  3  load size/sign.
- mem_alu_result  input  XLEN  ALU result; bits [1:0] are the load byte offset.
- mem_load_data  input  XLEN  raw aligned word from data memory.
- mem_pc_plus4  input  XLEN  link value.
- RegWrite  output  1  register file write enable.
- write_addr  output  REG_ADDR_W  register file write index.
- write_data  output  XLEN  register file write data.
- wb_fwd_valid  output  1  bypass entry valid (equals RegWrite).
- wb_fwd_rd  output  REG_ADDR_W  bypass index.
- wb_fwd_data  output  XLEN  bypass data (equals write_data).

Behaviour:
- **Stage register:** holds valid_q, reg_write_q, rd_q, sel_q, funct3_q, alu_q, load_q, pc4_q.
- **Update rules, priority order at each rising clk:**
  - reset==0: every register is cleared to 0.
  - else flush==1: valid_q and reg_write_q are cleared; other fields are don't-care (they may hold).
  - else stall==1: all fields hold.
  - else: all fields load from the mem_* inputs.
- **Flush vs stall:** flush beats stall.
- **Outputs:** purely combinational from the stage register; no input-to-output combinational path.
- **RegWrite:** valid_q & reg_write_q & (rd_q != 0). Writes to x0 are never issued.
- **write_addr:** rd_q.
- **write_data:** selected by sel_q (ALU, extended load, or PC+4).
- **Reset values:** RegWrite=0, write_addr=0, write_data=0, wb_fwd_valid=0, wb_fwd_rd=0, wb_fwd_data=0.
- **Latency:** inputs sampled at edge N, RegWrite asserted between N and N+1, register file updated at edge N+1. There is one cycle of exposure on the bypass.
- **Stall behaviour:** during stall, RegWrite stays asserted for a held valid instruction. The repeated identical write is intended and harmless.
- **Load extension (funct3, offset = alu_q[1:0]):**
  - 000 LB: byte at offset, sign-extended.
  - 100 LBU: byte at offset, zero-extended.
  - 001 LH: halfword [15:0] if offset[1]==0, else [31:16], sign-extended.
  - 101 LHU: same halfword selection, zero-extended.
  - 010 LW and any other code: full word; offset ignored.
- **Misalignment:** not trapped. LH at offset 1 behaves as offset 0; LH at offset 3 behaves as offset 2.
- **Bubbles:** never produce a write, regardless of the other fields.
- **Reset mid-stall or mid-flush:** reset wins and the stage becomes empty.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- **Defined:**
  - Adds output instret (64 bits), reset to 0.
  - Increments by 1 at every rising clk where reset==1, valid_q==1 and stall==0. A held instruction is counted once; a flushed-in bubble is never counted.
  - Wraps modulo 2^64.
- **Undefined:** no port and no counter logic.

Decomposition:
- **Package wb_pkg:**
  - XLEN and REG_ADDR_W constants.
  - result_sel encodings: RES_ALU, RES_LOAD, RES_PC4.
  - funct3 load encodings: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- **Sub-module load_extend (combinational):** inputs word, offset[1:0], funct3; output extended XLEN value. It is reused by the verification model.

Test Plan:
- Reset and ALU write: reset=0 for 2 cycles, check all outputs are 0. Then release and present mem_valid=1, reg_write=1, rd=5, sel=00, alu=0x0000_1234. After the next edge: RegWrite=1, write_addr=5, write_data=0x0000_1234, wb_fwd_data equal to write_data.
- x0 suppression: rd=0, reg_write=1, alu=0xFFFF_FFFF -> RegWrite=0 and wb_fwd_valid=0.
- Load extension, with load_data=0x80FF_7F01:
  - LB offset 3 -> 0xFFFF_FF80.
  - LBU offset 1 -> 0x0000_007F.
  - LH offset 2 -> 0xFFFF_80FF.
  - LHU offset 0 -> 0x0000_7F01.
  - LW offset 2 -> 0x80FF_7F01.
- Stall then flush: capture a valid ALU write to rd=7 and hold stall=1 for 3 cycles; RegWrite=1 and data are unchanged throughout. Then assert flush=1 together with stall=1; after the edge RegWrite=0.
- PC+4 select: sel=10, pc_plus4=0x0000_0104, rd=1 -> write_data=0x0000_0104.
- With WB_RETIRE_COUNT_EN defined: issue 4 valid instructions, 1 bubble, and 2 stall cycles on one instruction. Check instret==4 after they drain, and instret==0 after reset is pulsed.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and encodings for the MEM/WB writeback stage.
package wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Combinational sub-word load extraction and sign/zero extension (module load_extend).
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned Xlen = XLEN
) (
  input  logic [Xlen-1:0] word_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [Xlen-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    unique case (offset_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    // Misaligned halfwords fall back to the enclosing aligned halfword.
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(Xlen-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(Xlen-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(Xlen-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(Xlen-16){1'b0}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB stage: registers the MEM result, drives the register file write and the WB bypass.
// Optional retired-instruction counter enabled by WB_RETIRE_COUNT_EN.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = wb_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = wb_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [1:0]            mem_result_sel,
  input  logic [2:0]            mem_funct3,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [XLEN-1:0]       mem_load_data,
  input  logic [XLEN-1:0]       mem_pc_plus4,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]       write_data,
  output logic                  wb_fwd_valid,
  output logic [REG_ADDR_W-1:0] wb_fwd_rd,
  output logic [XLEN-1:0]       wb_fwd_data
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]           instret
`endif
);

  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [1:0]            sel_q, sel_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [XLEN-1:0]       alu_q, alu_d;
  logic [XLEN-1:0]       load_q, load_d;
  logic [XLEN-1:0]       pc4_q, pc4_d;
  logic [XLEN-1:0]       load_ext;

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    sel_d       = sel_q;
    funct3_d    = funct3_q;
    alu_d       = alu_q;
    load_d      = load_q;
    pc4_d       = pc4_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (!stall) begin
      valid_d     = mem_valid;
      reg_write_d = mem_reg_write;
      rd_d        = mem_rd;
      sel_d       = mem_result_sel;
      funct3_d    = mem_funct3;
      alu_d       = mem_alu_result;
      load_d      = mem_load_data;
      pc4_d       = mem_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      sel_q       <= '0;
      funct3_q    <= '0;
      alu_q       <= '0;
      load_q      <= '0;
      pc4_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      sel_q       <= sel_d;
      funct3_q    <= funct3_d;
      alu_q       <= alu_d;
      load_q      <= load_d;
      pc4_q       <= pc4_d;
    end
  end

  load_extend #(
    .Xlen(XLEN)
  ) u_load_extend (
    .word_i  (load_q),
    .offset_i(alu_q[1:0]),
    .funct3_i(funct3_q),
    .data_o  (load_ext)
  );

  always_comb begin
    RegWrite   = valid_q & reg_write_q & (rd_q != '0);
    write_addr = rd_q;
    write_data = alu_q;
    unique case (sel_q)
      RES_LOAD: write_data = load_ext;
      RES_PC4:  write_data = pc4_q;
      default:  write_data = alu_q;
    endcase
    wb_fwd_valid = RegWrite;
    wb_fwd_rd    = write_addr;
    wb_fwd_data  = write_data;
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] instret_q;

  // A held instruction retires only on the cycle it leaves the stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (valid_q && !stall) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule
